// File: rtl/button_event_sched.sv
// Turns debounced button levels into press/auto-repeat events, arbitrated
// round-robin onto a single valid/ready output register.
module button_event_sched #(
    parameter int els_p           = 5,
    parameter int tick_width_p    = 16,
    parameter int repeat_delay_p  = 8,
    parameter int repeat_period_p = 4,
    localparam int id_w_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int hold_w_lp = $clog2(repeat_delay_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [els_p-1:0]   buttons_i,
    output logic               v_o,
    output logic [id_w_lp-1:0] id_o,
    output logic               repeat_o,
    input  logic               ready_i,
    output logic               overrun_o,
    input  logic               clear_overrun_i
);

    logic [els_p-1:0]        prev_q;
    logic [els_p-1:0]        pend_q, pend_d;
    logic [els_p-1:0]        repf_q, repf_d;
    logic [els_p-1:0]        rise, rep, set, clr;
    logic [tick_width_p-1:0] pre_q;
    logic                    tick;
    logic [hold_w_lp-1:0]    hold_q [els_p];
    logic [hold_w_lp-1:0]    hold_d [els_p];
    logic [id_w_lp-1:0]      rr_q, rr_d, idx, id_q, id_d;
    logic                    any, load;
    logic                    v_q, v_d, rep_q, rep_d, ovr_q, ovr_d;

    assign tick = &pre_q;

    // Reload after a repeat so later repeats come every repeat_period_p ticks.
    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            hold_d[i] = hold_q[i];
            rep[i]    = 1'b0;
            if (!buttons_i[i] || !en_i) begin
                hold_d[i] = '0;
            end else if (tick) begin
                if (hold_q[i] == hold_w_lp'(repeat_delay_p - 1)) begin
                    rep[i]    = 1'b1;
                    hold_d[i] = hold_w_lp'(repeat_delay_p - repeat_period_p);
                end else begin
                    hold_d[i] = hold_q[i] + hold_w_lp'(1);
                end
            end
        end
    end

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < els_p; k++) begin
            if (!any && pend_q[(int'(rr_q) + k) % els_p]) begin
                any = 1'b1;
                idx = id_w_lp'((int'(rr_q) + k) % els_p);
            end
        end
    end

    always_comb begin
        load   = ~v_q | ready_i;
        clr    = (load && any) ? (els_p'(1) << idx) : '0;
        rise   = buttons_i & ~prev_q;
        set    = {els_p{en_i}} & (rise | rep);
        pend_d = set | (pend_q & ~clr);
        repf_d = (set & rep & ~rise) | (~set & repf_q);
        ovr_d  = clear_overrun_i ? 1'b0
                                 : (ovr_q | (|(set & pend_q & ~clr)));
        v_d    = v_q;
        id_d   = id_q;
        rep_d  = rep_q;
        rr_d   = rr_q;
        if (load) begin
            v_d = any;
            if (any) begin
                id_d  = idx;
                rep_d = repf_q[idx];
                if (idx == id_w_lp'(els_p - 1)) rr_d = '0;
                else rr_d = idx + id_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q <= '0;
            pend_q <= '0;
            repf_q <= '0;
            pre_q  <= '0;
            rr_q   <= '0;
            id_q   <= '0;
            v_q    <= 1'b0;
            rep_q  <= 1'b0;
            ovr_q  <= 1'b0;
            for (int i = 0; i < els_p; i++) hold_q[i] <= '0;
        end else begin
            prev_q <= buttons_i;
            pend_q <= pend_d;
            repf_q <= repf_d;
            pre_q  <= pre_q + tick_width_p'(1);
            rr_q   <= rr_d;
            id_q   <= id_d;
            v_q    <= v_d;
            rep_q  <= rep_d;
            ovr_q  <= ovr_d;
            for (int i = 0; i < els_p; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign v_o       = v_q;
    assign id_o      = id_q;
    assign repeat_o  = rep_q;
    assign overrun_o = ovr_q;

endmodule

// File: tb/tb_button_event_sched.sv
// Bench for button_event_sched: vector table, directed corner sequences and
// random stimulus against a tick-count reference model.
module tb_button_event_sched;

    localparam int N  = 5;
    localparam int TW = 2;
    localparam int D  = 8;
    localparam int P  = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         rdy = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] btn = '0;
    logic         v, rp, ov;
    logic [2:0]   id;

    int checks = 0;
    int failures = 0;

    button_event_sched #(
        .els_p(N), .tick_width_p(TW),
        .repeat_delay_p(D), .repeat_period_p(P)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .buttons_i(btn),
        .v_o(v), .id_o(id), .repeat_o(rp), .ready_i(rdy),
        .overrun_o(ov), .clear_overrun_i(clr)
    );

    always #5 clk = ~clk;

    // Reference state: held ticks counted since press, not a reload counter.
    bit m_prev [N];
    bit m_pend [N];
    bit m_kind [N];
    int m_ht   [N];
    int m_pc, m_rr, m_id;
    bit m_v, m_rep, m_ov;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_kind[i] = 0; m_ht[i] = 0;
        end
        m_pc = 0; m_rr = 0; m_id = 0; m_v = 0; m_rep = 0; m_ov = 0;
    endfunction

    function automatic void m_edge();
        bit tick, ld, ovf;
        bit rise [N];
        bit rpt  [N];
        bit set  [N];
        int pick;
        if (!rst_n) begin
            m_reset();
            return;
        end
        tick = (m_pc == (1 << TW) - 1);
        m_pc = (m_pc + 1) % (1 << TW);
        for (int i = 0; i < N; i++) begin
            rise[i] = btn[i] && !m_prev[i];
            rpt[i]  = 0;
            if (!btn[i] || !en) m_ht[i] = 0;
            else if (tick) begin
                m_ht[i]++;
                rpt[i] = (m_ht[i] >= D) && ((m_ht[i] - D) % P == 0);
            end
            set[i]    = en && (rise[i] || rpt[i]);
            m_prev[i] = btn[i];
        end
        ld = !m_v || rdy;
        pick = -1;
        if (ld)
            for (int k = 0; k < N; k++)
                if (pick < 0 && m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
        ovf = 0;
        for (int i = 0; i < N; i++)
            if (set[i] && m_pend[i] && pick != i) ovf = 1;
        if (ld) begin
            if (pick >= 0) begin
                m_v = 1; m_id = pick; m_rep = m_kind[pick];
                m_pend[pick] = 0; m_rr = (pick + 1) % N;
            end else m_v = 0;
        end
        for (int i = 0; i < N; i++)
            if (set[i]) begin
                m_pend[i] = 1;
                m_kind[i] = rpt[i] && !rise[i];
            end
        m_ov = clr ? 0 : (m_ov || ovf);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk("model_v", v, m_v);
        chk("model_id", id, m_id);
        chk("model_rep", rp, m_rep);
        chk("model_ovr", ov, m_ov);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_v", v, 0);
        chk("rst_id", id, 0);
        chk("rst_rep", rp, 0);
        chk("rst_ovr", ov, 0);
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] b;
        bit en, rdy, clr, v;
        int id;
        bit rep, ovr;
    } vec_t;

    vec_t tbl [22];
    int   fresh, reps, rep_at [2], ev, exp_ids [3];

    initial begin
        tbl[0]  = '{5'b00100, 1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{5'b00100, 1, 1, 0, 1, 2, 0, 0};
        tbl[2]  = '{5'b10011, 1, 1, 0, 0, 2, 0, 0};
        tbl[3]  = '{5'b10011, 1, 1, 0, 1, 4, 0, 0};
        tbl[4]  = '{5'b10011, 1, 1, 0, 1, 0, 0, 0};
        tbl[5]  = '{5'b10011, 1, 1, 0, 1, 1, 0, 0};
        tbl[6]  = '{5'b10011, 1, 1, 0, 0, 1, 0, 0};
        tbl[7]  = '{5'b00000, 1, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{5'b00010, 1, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{5'b00010, 1, 0, 0, 1, 1, 0, 0};
        tbl[10] = '{5'b00000, 1, 0, 0, 1, 1, 0, 0};
        tbl[11] = '{5'b00010, 1, 0, 0, 1, 1, 0, 0};
        tbl[12] = '{5'b00000, 1, 0, 0, 1, 1, 0, 0};
        tbl[13] = '{5'b00010, 1, 0, 0, 1, 1, 0, 1};
        tbl[14] = '{5'b00010, 1, 1, 1, 1, 1, 0, 0};
        tbl[15] = '{5'b00010, 1, 1, 0, 0, 1, 0, 0};
        tbl[16] = '{5'b00000, 0, 1, 0, 0, 1, 0, 0};
        tbl[17] = '{5'b00100, 0, 1, 0, 0, 1, 0, 0};
        tbl[18] = '{5'b00100, 0, 1, 0, 0, 1, 0, 0};
        tbl[19] = '{5'b01000, 1, 0, 0, 0, 1, 0, 0};
        tbl[20] = '{5'b01000, 0, 0, 0, 1, 3, 0, 0};
        tbl[21] = '{5'b00000, 0, 1, 0, 0, 3, 0, 0};

        do_reset();
        for (int r = 0; r < 22; r++) begin
            btn = tbl[r].b; en = tbl[r].en; rdy = tbl[r].rdy; clr = tbl[r].clr;
            step();
            chk($sformatf("tbl%0d_v", r), v, tbl[r].v);
            chk($sformatf("tbl%0d_id", r), id, tbl[r].id);
            chk($sformatf("tbl%0d_rep", r), rp, tbl[r].rep);
            chk($sformatf("tbl%0d_ovr", r), ov, tbl[r].ovr);
        end
        clr = 1'b0;

        // Simultaneous presses from rr=0, then rr must have wrapped to 0.
        btn = '0; en = 1'b1; rdy = 1'b1;
        do_reset();
        exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 4;
        btn = 5'b10011;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rr_v", v, 1);
            chk("rr_id", id, exp_ids[k]);
        end
        step();
        chk("rr_idle", v, 0);
        btn = '0;
        step();
        btn = 5'b10001;
        step();
        step();
        chk("rr_wrap_id", id, 0);

        // Held button: fresh at edge 2, repeats at edges 33 and 49.
        btn = '0;
        do_reset();
        btn = 5'b01000;
        fresh = 0; reps = 0; rep_at[0] = 0; rep_at[1] = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 61) btn = '0;
            step();
            if (v && !rp) fresh++;
            if (v && rp) begin
                if (reps < 2) rep_at[reps] = c;
                reps++;
                chk("hold_id", id, 3);
            end
        end
        chk("hold_fresh", fresh, 1);
        chk("hold_reps", reps, 2);
        chk("hold_rep1_edge", rep_at[0], 33);
        chk("hold_rep2_edge", rep_at[1], 49);

        // Reset mid-repeat with the button still held: one fresh event.
        btn = '0;
        do_reset();
        btn = 5'b00001;
        repeat (40) step();
        do_reset();
        ev = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 2) begin
                chk("rstheld_v", v, 1);
                chk("rstheld_rep", rp, 0);
            end
            if (v) ev++;
        end
        chk("rstheld_events", ev, 1);

        btn = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 39) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 49) == 0) en = ~en;
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
